// File: rtl/debug_dump_seq.sv
// Debug dump sequencer: freezes the CPU, then streams PC, r0..r31 and optionally DM words (DBG_DM_DUMP_EN).
// Latency: first out_valid 3 cycles after the request; one word per 3 cycles with out_ready held high.
// Backpressure: out_valid/out_data/out_tag hold while out_ready is low; the sequence waits in PUSH.
`ifndef DM_ADDR_BIT
`define DM_ADDR_BIT 12
`endif

module debug_dump_seq #(
    parameter int DM_BASE  = 0,
    parameter int DM_WORDS = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    halted,
    input  logic [31:0]             pc_dbg,
    output logic [4:0]              regfile_req_dbg,
    input  logic [31:0]             regfile_data_dbg,
    output logic [`DM_ADDR_BIT-1:0] datamem_addr_dbg,
    input  logic [31:0]             datamem_data_dbg,
    output logic                    cpu_en,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [31:0]             out_data,
    output logic [7:0]              out_tag,
    output logic                    busy,
    output logic                    done
);

    localparam int ADDR_W = `DM_ADDR_BIT;
`ifdef DBG_DM_DUMP_EN
    localparam bit DM_EN = 1'b1;
`else
    localparam bit DM_EN = 1'b0;
`endif
    localparam int         N_WORDS = 33 + (DM_EN ? DM_WORDS : 0);
    localparam logic [6:0] LAST    = 7'(N_WORDS - 1);

    typedef enum logic [2:0] {IDLE, SETUP, CAPT, PUSH, FIN} state_t;

    state_t            state;
    logic [6:0]        widx;
    logic              halted_q;
    logic              req;
    logic [6:0]        w_sel;
    logic [31:0]       dm_off;
    logic [4:0]        sel_reg;
    logic [ADDR_W-1:0] sel_addr;
    logic [7:0]        cap_tag;
    logic [31:0]       cap_data;

    assign req = start | (halted & ~halted_q);

    // Word index 0 is the PC, 1..32 are r0..r31, 33.. are DM words.
    always_comb begin
        w_sel    = (state == IDLE) ? 7'd0 : widx + 7'd1;
        dm_off   = 32'(w_sel - 7'd33);
        sel_reg  = '0;
        sel_addr = '0;
        if (w_sel >= 7'd1 && w_sel <= 7'd32)
            sel_reg = 5'(w_sel - 7'd1);
        else if (DM_EN && w_sel >= 7'd33)
            sel_addr = ADDR_W'(32'(DM_BASE) + (dm_off << 2));
    end

    always_comb begin
        cap_tag  = 8'h20;
        cap_data = pc_dbg;
        if (widx >= 7'd33) begin
            cap_tag  = 8'h40 + 8'(widx - 7'd33);
            cap_data = datamem_data_dbg;
        end else if (widx != 7'd0) begin
            cap_tag  = 8'(widx - 7'd1);
            cap_data = regfile_data_dbg;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= IDLE;
            widx             <= '0;
            halted_q         <= 1'b1;
            regfile_req_dbg  <= '0;
            datamem_addr_dbg <= '0;
            cpu_en           <= 1'b1;
            out_valid        <= 1'b0;
            out_data         <= '0;
            out_tag          <= '0;
            busy             <= 1'b0;
            done             <= 1'b0;
        end else begin
            halted_q <= halted;
            case (state)
                IDLE: if (req) begin
                    state            <= SETUP;
                    widx             <= '0;
                    regfile_req_dbg  <= sel_reg;
                    datamem_addr_dbg <= sel_addr;
                    busy             <= 1'b1;
                    cpu_en           <= 1'b0;
                end
                SETUP: state <= CAPT;
                CAPT: begin
                    out_data  <= cap_data;
                    out_tag   <= cap_tag;
                    out_valid <= 1'b1;
                    state     <= PUSH;
                end
                PUSH: if (out_ready) begin
                    out_valid <= 1'b0;
                    if (widx == LAST) begin
                        state            <= FIN;
                        done             <= 1'b1;
                        regfile_req_dbg  <= '0;
                        datamem_addr_dbg <= '0;
                    end else begin
                        state            <= SETUP;
                        widx             <= widx + 7'd1;
                        regfile_req_dbg  <= sel_reg;
                        datamem_addr_dbg <= sel_addr;
                    end
                end
                FIN: begin
                    state  <= IDLE;
                    widx   <= '0;
                    done   <= 1'b0;
                    busy   <= 1'b0;
                    cpu_en <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_debug_dump_seq.sv
// Bench for debug_dump_seq: table of dump scenarios plus reset/abort sequences, scored against a word list model.
`ifndef DM_ADDR_BIT
`define DM_ADDR_BIT 12
`endif

module tb_debug_dump_seq;

    localparam int AW          = `DM_ADDR_BIT;
    localparam int TB_DM_BASE  = (1 << AW) - 4;
    localparam int TB_DM_WORDS = 2;
`ifdef DBG_DM_DUMP_EN
    localparam int N_WORDS = 33 + TB_DM_WORDS;
`else
    localparam int N_WORDS = 33;
`endif

    logic          clk = 1'b0;
    logic          rst, start, halted, out_ready;
    logic [31:0]   pc_dbg, regfile_data_dbg, datamem_data_dbg;
    logic [4:0]    regfile_req_dbg;
    logic [AW-1:0] datamem_addr_dbg;
    logic          cpu_en, out_valid, busy, done;
    logic [31:0]   out_data;
    logic [7:0]    out_tag;

    int checks   = 0;
    int failures = 0;

    logic [31:0] regs [32];
    logic [31:0] exp_d [$];
    logic [7:0]  exp_t [$];

    typedef struct {
        bit use_start;
        bit use_halt;
        int mode;       // 0 ready high, 1 ready pattern 1-0-0-1, 2 random ready
        bit mid_start;
        bit fixed;
        int exp_lat;
        int exp_words;
    } vec_t;

    vec_t vecs [9];

    debug_dump_seq #(.DM_BASE(TB_DM_BASE), .DM_WORDS(TB_DM_WORDS)) dut (
        .clk(clk), .rst(rst), .start(start), .halted(halted), .pc_dbg(pc_dbg),
        .regfile_req_dbg(regfile_req_dbg), .regfile_data_dbg(regfile_data_dbg),
        .datamem_addr_dbg(datamem_addr_dbg), .datamem_data_dbg(datamem_data_dbg),
        .cpu_en(cpu_en), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_tag(out_tag), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] dm_word(input logic [AW-1:0] a);
        return 32'hD000_0000 | 32'(a);
    endfunction

    // CPU debug ports return data one cycle after the index/address.
    always @(posedge clk) begin
        regfile_data_dbg <= regs[regfile_req_dbg];
        datamem_data_dbg <= dm_word(datamem_addr_dbg);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic build_expected();
        exp_d.delete();
        exp_t.delete();
        exp_d.push_back(pc_dbg);
        exp_t.push_back(8'h20);
        for (int n = 0; n < 32; n++) begin
            exp_d.push_back(regs[n]);
            exp_t.push_back(8'(n));
        end
`ifdef DBG_DM_DUMP_EN
        for (int k = 0; k < TB_DM_WORDS; k++) begin
            exp_d.push_back(dm_word(AW'(TB_DM_BASE + 4 * k)));
            exp_t.push_back(8'(8'h40 + k));
        end
`endif
    endtask

    task automatic load_cpu(input bit fixed);
        pc_dbg = fixed ? 32'h0000_0040 : $urandom;
        for (int n = 0; n < 32; n++) regs[n] = fixed ? 32'(n + 32'h100) : $urandom;
        build_expected();
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic run_dump(input vec_t v);
        int lat, got, cyc, last_acc, seen_busy;
        bit rdy, stalled;
        logic [31:0] hold_d;
        logic [7:0]  hold_t;
        halted = 1'b0; start = 1'b0; out_ready = 1'b0;
        tick();
        load_cpu(v.fixed);
        start  = v.use_start;
        halted = v.use_halt;
        lat = 0;
        do begin
            tick();
            start = 1'b0;
            lat++;
        end while (!out_valid && lat < 10);
        chk("first_valid_latency", lat, v.exp_lat);

        got = 0; cyc = 0; last_acc = 0; stalled = 0; hold_d = '0; hold_t = '0;
        while (got < v.exp_words && cyc < 3000) begin
            chk("cpu_en_low", cpu_en, 0);
            chk("busy_high", busy, 1);
            chk("done_low_mid", done, 0);
`ifndef DBG_DM_DUMP_EN
            chk("dm_addr_zero", datamem_addr_dbg, 0);
`endif
            if (stalled) begin
                chk("stall_valid", out_valid, 1);
                chk("stall_data", out_data, hold_d);
                chk("stall_tag", out_tag, hold_t);
            end
            case (v.mode)
                0:       rdy = 1'b1;
                1:       rdy = (cyc % 4 == 0) || (cyc % 4 == 3);
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            out_ready = rdy;
            start = v.mid_start && (cyc == 20);
            if (out_valid && rdy) begin
                if (got < exp_d.size()) begin
                    chk($sformatf("tag[%0d]", got), out_tag, exp_t[got]);
                    chk($sformatf("data[%0d]", got), out_data, exp_d[got]);
                end
                if (v.mode == 0 && got > 0) chk("word_interval", cyc - last_acc, 3);
                last_acc = cyc;
                got++;
            end
            stalled = out_valid && !rdy;
            hold_d  = out_data;
            hold_t  = out_tag;
            tick();
            cyc++;
        end
        start = 1'b0;
        out_ready = 1'b0;
        chk("word_count", got, v.exp_words);
        chk("done_after_last", done, 1);
        chk("valid_after_last", out_valid, 0);
        tick();
        chk("done_pulse_end", done, 0);
        chk("busy_idle", busy, 0);
        chk("cpu_en_idle", cpu_en, 1);
        chk("reg_idx_idle", regfile_req_dbg, 0);
        chk("dm_addr_idle", datamem_addr_dbg, 0);
        seen_busy = 0;
        repeat (6) begin
            tick();
            if (busy || out_valid || done) seen_busy++;
        end
        chk("no_queued_dump", seen_busy, 0);
    endtask

    initial begin
        int got, cyc, seen_done;
        rst = 1'b1; start = 1'b0; halted = 1'b1; out_ready = 1'b0; pc_dbg = '0;
        for (int n = 0; n < 32; n++) regs[n] = '0;

        vecs[0] = '{1, 0, 0, 0, 1, 3, N_WORDS};
        vecs[1] = '{1, 0, 1, 0, 0, 3, N_WORDS};
        vecs[2] = '{1, 1, 0, 1, 0, 3, N_WORDS};
        vecs[3] = '{0, 1, 2, 0, 0, 3, N_WORDS};
        vecs[4] = '{1, 0, 2, 1, 0, 3, N_WORDS};
        for (int i = 5; i < 9; i++) begin
            vecs[i].use_halt  = 1'($urandom_range(0, 1));
            vecs[i].use_start = vecs[i].use_halt ? 1'($urandom_range(0, 1)) : 1'b1;
            vecs[i].mode      = $urandom_range(0, 2);
            vecs[i].mid_start = 1'($urandom_range(0, 1));
            vecs[i].fixed     = 1'b0;
            vecs[i].exp_lat   = 3;
            vecs[i].exp_words = N_WORDS;
        end

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_tag", out_tag, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_cpu_en", cpu_en, 1);
        chk("rst_reg_idx", regfile_req_dbg, 0);
        chk("rst_dm_addr", datamem_addr_dbg, 0);
        rst = 1'b0;
        repeat (4) tick();
        chk("halted_high_from_reset_no_dump", busy, 0);

        for (int i = 0; i < 9; i++) run_dump(vecs[i]);

        // Abort a dump with reset after ten words have been accepted.
        halted = 1'b0;
        load_cpu(1'b0);
        start = 1'b1;
        out_ready = 1'b1;
        tick();
        start = 1'b0;
        got = 0; cyc = 0;
        while (got < 10 && cyc < 200) begin
            if (out_valid) got++;
            tick();
            cyc++;
        end
        chk("abort_words_before_rst", got, 10);
        rst = 1'b1;
        tick();
        chk("abort_out_valid", out_valid, 0);
        chk("abort_cpu_en", cpu_en, 1);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        rst = 1'b0;
        out_ready = 1'b0;
        seen_done = 0;
        repeat (5) begin
            tick();
            if (done || busy) seen_done++;
        end
        chk("abort_no_done", seen_done, 0);
        run_dump('{1, 0, 0, 0, 1, 3, N_WORDS});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
